// File: rtl/controlador_pkg.sv
// Shared constants and the sine-table generator for the ROM-driven PWM controller.
package controlador_pkg;

  localparam int ADDR_W     = 10;                        // 1024 samples per sine cycle
  localparam int DATA_W     = 12;                        // unsigned ROM word
  localparam int PWM_W      = 12;                        // PWM period = 2**PWM_W clk
  localparam int SW_W       = 4;                         // gain switch width
  localparam int GAIN_SHIFT = 10;                        // gain applied as {sw, 10'b0}
  localparam int DUTY_W     = DATA_W + SW_W + GAIN_SHIFT; // 26-bit product
  localparam int THR_LSB    = 14;                        // thr = duty[25:14] for PWM_W = 12

  // Fixed-point constants used to build the table at elaboration (Q30 format)
  localparam longint PI_HALF_Q30 = 64'sd1686629713;
  localparam longint Q30_HALF    = 64'sd536870912;
  localparam longint SINE_MID    = 64'sd1 <<< (DATA_W - 1);
  localparam longint SINE_AMP    = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
  localparam int     SIN_TERMS   = 7;

  // rom[i] = 2048 + round(2047 * sin(2*pi*i/1024)), integer-only so it folds to constants.
  // Quarter-wave symmetry keeps the Taylor argument within [0, pi/2].
  function automatic logic [DATA_W-1:0] sine_word(input int unsigned idx);
    int unsigned quarter;
    int unsigned quad;
    int unsigned k;
    longint      x;
    longint      x2;
    longint      term;
    longint      acc;
    longint      mag;
    longint      word;
    quarter = 32'd1 << (ADDR_W - 2);
    quad    = idx / quarter;
    k       = idx % quarter;
    if ((quad == 32'd1) || (quad == 32'd3)) begin
      k = quarter - k;
    end
    x    = (PI_HALF_Q30 * longint'(k)) / longint'(quarter);
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int n = 1; n <= SIN_TERMS; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    mag = (acc * SINE_AMP + Q30_HALF) >>> 30;
    if (quad >= 32'd2) begin
      word = SINE_MID - mag;
    end else begin
      word = SINE_MID + mag;
    end
    return word[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/rom_seno_1024x12.sv
// 1024x12 sine table with a registered (1-clk latency) synchronous read.
module rom_seno_1024x12
  import controlador_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] w_rom [DEPTH];
  logic [DATA_W-1:0] r_data;

  // Table contents are elaboration-time constants, so this maps onto ROM/LUT storage
  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic [DATA_W-1:0] C_WORD = sine_word(g);
    assign w_rom[g] = C_WORD;
  end

  // Registered read port, cleared by reset so dataROM starts at zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= {DATA_W{1'b0}};
    end else begin
      r_data <= w_rom[i_addr];
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/controlador_top_vrom.sv
// ROM-driven PWM generator: one sine sample per PWM period, scaled by the switch gain.
module controlador_top_vrom
  import controlador_pkg::*;
#(
  parameter int PWM_W = controlador_pkg::PWM_W
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [SW_W-1:0]   sw,
  output logic [DATA_W-1:0] dataROM,
  output logic [ADDR_W-1:0] add,
  output logic [DUTY_W-1:0] duty,
  output logic              PWMout
);

  // Threshold is always the top PWM_W bits of the product (bits [25:14] at 12-bit PWM)
  localparam int THR_SHIFT = THR_LSB + controlador_pkg::PWM_W - PWM_W;
  localparam logic [PWM_W-1:0]  CNT_LAST = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0]  CNT_ONE  = {{(PWM_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [PWM_W-1:0]  r_cnt;
  logic [PWM_W-1:0]  r_thr;
  logic [ADDR_W-1:0] r_add;
  logic [DUTY_W-1:0] r_duty;
  logic              r_pwm;
  logic [DATA_W-1:0] w_data;
  logic              w_period_end;
  logic [DUTY_W-1:0] w_gain;
  logic [DUTY_W-1:0] w_product;

  assign w_period_end = (r_cnt == CNT_LAST);
  assign w_gain       = DUTY_W'({sw, {GAIN_SHIFT{1'b0}}});
  assign w_product    = DUTY_W'(w_data) * w_gain;

  rom_seno_1024x12 u_rom (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_addr (r_add),
    .o_data (w_data)
  );

  // Free-running PWM counter; sample index and threshold advance only at the period end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {PWM_W{1'b0}};
      r_add <= {ADDR_W{1'b0}};
      r_thr <= {PWM_W{1'b0}};
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
      if (w_period_end) begin
        r_add <= r_add + ADDR_ONE;
        r_thr <= r_duty[THR_SHIFT +: PWM_W];
      end else begin
        r_add <= r_add;
        r_thr <= r_thr;
      end
    end
  end

  // Scaled duty, recomputed every clock so a gain change is ready before the next period end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty <= {DUTY_W{1'b0}};
    end else begin
      r_duty <= w_product;
    end
  end

  // Registered PWM comparator; thr never reaches 2**PWM_W so the output always drops each period
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= (r_cnt < r_thr);
    end
  end

  assign dataROM = w_data;
  assign add     = r_add;
  assign duty    = r_duty;
  assign PWMout  = r_pwm;

endmodule

// File: tb/tb_controlador_top_vrom.sv
// Self-checking bench: a full-size instance for period-accurate checks and a 16-clk-period
// instance for walking the whole sine table within a short run.
module tb_controlador_top_vrom;

  typedef struct {
    logic [9:0]  addr;
    logic [3:0]  sw;
    logic [11:0] data;
    logic [25:0] duty;
    int          high;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [3:0]  sw_a, sw_b;
  logic [11:0] data_a, data_b;
  logic [9:0]  add_a, add_b;
  logic [25:0] duty_a, duty_b;
  logic        pwm_a, pwm_b;

  int n_checks = 0;
  int n_fail   = 0;

  controlador_top_vrom u_dut (
    .clk(clk), .rst(rst_a), .sw(sw_a), .dataROM(data_a),
    .add(add_a), .duty(duty_a), .PWMout(pwm_a)
  );

  controlador_top_vrom #(.PWM_W(4)) u_dut_fast (
    .clk(clk), .rst(rst_b), .sw(sw_b), .dataROM(data_b),
    .add(add_b), .duty(duty_b), .PWMout(pwm_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_add_b(input logic [9:0] target, input string name);
    int budget;
    budget = 4096;
    while ((add_b !== target) && (budget > 0)) begin
      @(negedge clk);
      budget--;
    end
    check(name, add_b, target);
  endtask

  initial begin
    vec_t vecs [8];
    int   hi;
    int   k;
    int   bad;
    vecs[0] = '{addr:10'd0,   sw:4'd15, data:12'd2048, duty:26'd31457280, high:7};
    vecs[1] = '{addr:10'd128, sw:4'd10, data:12'd3495, duty:26'd35788800, high:8};
    vecs[2] = '{addr:10'd256, sw:4'd15, data:12'd4095, duty:26'd62899200, high:14};
    vecs[3] = '{addr:10'd384, sw:4'd3,  data:12'd3495, duty:26'd10736640, high:2};
    vecs[4] = '{addr:10'd512, sw:4'd0,  data:12'd2048, duty:26'd0,        high:0};
    vecs[5] = '{addr:10'd640, sw:4'd8,  data:12'd601,  duty:26'd4923392,  high:1};
    vecs[6] = '{addr:10'd768, sw:4'd15, data:12'd1,    duty:26'd15360,    high:0};
    vecs[7] = '{addr:10'd896, sw:4'd15, data:12'd601,  duty:26'd9231360,  high:2};

    rst_a = 1'b1; sw_a = 4'd15;
    rst_b = 1'b1; sw_b = 4'd15;
    repeat (2) @(negedge clk);
    check("rst_a_data", data_a, 12'd0);
    check("rst_a_add",  add_a,  10'd0);
    check("rst_a_duty", duty_a, 26'd0);
    check("rst_a_pwm",  pwm_a,  1'b0);
    check("rst_b_data", data_b, 12'd0);
    check("rst_b_add",  add_b,  10'd0);
    check("rst_b_duty", duty_b, 26'd0);
    check("rst_b_pwm",  pwm_b,  1'b0);

    // Full-size: first period dark, second period 1920 high at sw=15
    rst_a = 1'b0;
    hi = 0;
    for (int i = 1; i <= 4096; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("a_data_lat1", data_a, 12'd2048);
        check("a_duty_lat1", duty_a, 26'd0);
      end
      if (i == 2) check("a_duty_lat2", duty_a, 26'd31457280);
      if (pwm_a === 1'b1) hi++;
    end
    check("a_p1_high", hi, 0);
    check("a_p1_add", add_a, 10'd1);
    hi = 0;
    for (int i = 1; i <= 4096; i++) begin
      @(negedge clk);
      if (pwm_a === 1'b1) hi++;
    end
    check("a_p2_high", hi, 1920);
    check("a_p2_add", add_a, 10'd2);

    // Full-size: gain 15 -> 8 mid first period, then 8 -> 0 mid second period
    rst_a = 1'b1; sw_a = 4'd15;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    hi = 0;
    for (int i = 1; i <= 4096; i++) begin
      @(negedge clk);
      if (pwm_a === 1'b1) hi++;
      if (i == 1000) sw_a = 4'd8;
      if (i == 1005) check("a_duty_sw8", duty_a, 26'd16777216);
    end
    check("a_sw_p1_high", hi, 0);
    hi = 0;
    for (int i = 1; i <= 4096; i++) begin
      @(negedge clk);
      if (pwm_a === 1'b1) hi++;
      if (i == 10) sw_a = 4'd0;
    end
    check("a_sw8_p2_high", hi, 1024);
    check("a_duty_sw0", duty_a, 26'd0);
    hi = 0;
    for (int i = 1; i <= 8192; i++) begin
      @(negedge clk);
      if (pwm_a === 1'b1) hi++;
    end
    check("a_sw0_high", hi, 0);
    check("a_sw0_add", add_a, 10'd4);

    // Short-period instance: table of sample/gain points across the sine cycle
    rst_b = 1'b0;
    for (int v = 0; v < 8; v++) begin
      wait_add_b(vecs[v].addr, $sformatf("b_reach[%0d]", v));
      sw_b = vecs[v].sw;
      repeat (3) @(negedge clk);
      check($sformatf("b_data[%0d]", v), data_b, vecs[v].data);
      check($sformatf("b_duty[%0d]", v), duty_b, vecs[v].duty);
      wait_add_b(vecs[v].addr + 10'd1, $sformatf("b_next[%0d]", v));
      hi = 0;
      repeat (16) begin
        @(negedge clk);
        if (pwm_b === 1'b1) hi++;
      end
      check($sformatf("b_high[%0d]", v), hi, vecs[v].high);
    end

    // Address wrap 1023 -> 0 lands exactly on a period boundary
    wait_add_b(10'd1023, "b_reach_1023");
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((add_b !== 10'd0) && (k < 40));
    check("b_wrap_period", k, 16);
    hi = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) check("b_wrap_data", data_b, 12'd2048);
      if (pwm_b === 1'b1) hi++;
    end
    check("b_wrap_high", hi, 7);

    // Reset mid-period at add=37: everything clears on that edge and restarts from 0
    wait_add_b(10'd37, "b_reach_37");
    repeat (5) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check("b_mid_rst_data", data_b, 12'd0);
    check("b_mid_rst_add",  add_b,  10'd0);
    check("b_mid_rst_duty", duty_b, 26'd0);
    check("b_mid_rst_pwm",  pwm_b,  1'b0);
    rst_b = 1'b0;
    bad = 0;
    hi  = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) check("b_restart_data", data_b, 12'd2048);
      if ((i <= 15) && (add_b !== 10'd0)) bad++;
      if (pwm_b === 1'b1) hi++;
    end
    check("b_restart_hold0", bad, 0);
    check("b_restart_add1", add_b, 10'd1);
    check("b_restart_dark", hi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
